// File: rtl/mem_sp_ctrl_pkg.sv
// Shared definitions for the single-port scratch memory controller.
// Optional feature macro: MEM_SP_PARITY_EN (adds one even-parity bit per entry).
package mem_pkg;

    // Controller FSM states: INIT sweeps the array to zero, RUN serves requests.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Extra storage bits per entry for the parity feature.
`ifdef MEM_SP_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/mem_sp_ctrl_if.sv
// Request/response bus between a datapath master and mem_sp_ctrl.
// The perr signal is only meaningful when MEM_SP_PARITY_EN is defined.
interface mem_sp_ctrl_if #(
    parameter int W = 8,
    parameter int L = 16
);
    localparam int AW = $clog2(L);

    // Request side
    logic          req;
    logic          wrt_read;
    logic [AW-1:0] add;
    logic [W-1:0]  write;
    logic          clear;

    // Response side
    logic          ready;
    logic [W-1:0]  out;
    logic          out_valid;
    logic          err;
    logic          perr;

    modport master (
        output req, wrt_read, add, write, clear,
        input  ready, out, out_valid, err, perr
    );

    modport slave (
        input  req, wrt_read, add, write, clear,
        output ready, out, out_valid, err, perr
    );

endinterface

// File: rtl/mem_sp_array.sv
// Register-array storage: L entries of DW bits, synchronous write port and
// a registered read port that holds its value until the next enabled read.
module mem_sp_array #(
    parameter int L  = 16,
    parameter int DW = 8,
    parameter int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [L];
    logic [DW-1:0] r_rdata;

    // Write port: one entry per cycle when enabled.
    // NOTE: storage has no reset; the controller's INIT sweep zeroes it, so it
    // maps onto plain RAM/flops without a reset net.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values.
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: capture the addressed entry; hold it between reads.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_sp_ctrl.sv
// Single-port memory controller: zero-init sweep after reset or clear,
// request/ready handshake, 1-cycle registered reads, out-of-range detection.
// Optional feature macro: MEM_SP_PARITY_EN (even parity stored per entry,
// checked on every in-range read and reported on perr).
module mem_sp_ctrl
    import mem_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_sp_ctrl_if.slave bus
);

    localparam int AW = $clog2(L);
    localparam int DW = W + PAR_W;

    localparam logic [AW-1:0] LAST_IDX = AW'(L - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(L);

    state_e        r_state;
    state_e        w_next_state;
    logic [AW-1:0] r_cnt;

    logic          r_out_valid;
    logic          r_err;
    logic          r_rd_ok;     // last read was in range: out shows array data

    logic          w_ready;
    logic          w_sweep;
    logic          w_sweep_done;
    logic          w_accept;
    logic          w_in_range;
    logic          w_we;
    logic          w_re;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_req_word;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rd_q;

    // Zero-extend both sides so the compare also works for power-of-two L.
    assign w_in_range   = ({1'b0, bus.add} < DEPTH);
    assign w_sweep_done = (r_cnt == LAST_IDX);
    assign w_accept     = bus.req && w_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: sweep completes into RUN; clear in RUN restarts the sweep.
    always_comb begin
        // NOTE: default first so every path assigns the signal (no latch).
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (w_sweep_done) w_next_state = ST_RUN;
            ST_RUN:  if (bus.clear)    w_next_state = ST_INIT;
            default: w_next_state = ST_INIT;
        endcase
    end

    // FSM outputs: sweep enable in INIT, combinational ready in RUN.
    always_comb begin
        w_ready = 1'b0;
        w_sweep = 1'b0;
        case (r_state)
            ST_INIT: w_sweep = 1'b1;
            ST_RUN:  w_ready = !bus.clear;
            default: w_sweep = 1'b1;
        endcase
    end

    // Sweep counter: walks 0..L-1 in INIT, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= w_sweep_done ? '0 : r_cnt + AW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Write word as stored: data plus even parity when the feature is built in.
`ifdef MEM_SP_PARITY_EN
    assign w_req_word = {^bus.write, bus.write};
`else
    assign w_req_word = bus.write;
`endif

    // Array port steering: the sweep owns the array in INIT, requests in RUN.
    assign w_we    = w_sweep || (w_accept && bus.wrt_read && w_in_range);
    assign w_re    = w_accept && !bus.wrt_read && w_in_range;
    assign w_addr  = w_sweep ? r_cnt : bus.add;
    assign w_wdata = w_sweep ? '0 : w_req_word;

    mem_sp_array #(
        .L  (L),
        .DW (DW),
        .AW (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_addr),
        .o_rdata (w_rd_q)
    );

    // Response strobes and read-source flag, one cycle after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            r_out_valid <= w_accept && !bus.wrt_read;
            r_err       <= w_accept && !w_in_range;
            if (w_accept && !bus.wrt_read) begin
                r_rd_ok <= w_in_range;
            end
        end
    end

    // An out-of-range read (or reset) forces out to zero until the next
    // in-range read; the array's read register supplies the held value.
    assign bus.ready     = w_ready;
    assign bus.out       = r_rd_ok ? w_rd_q[W-1:0] : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;

`ifdef MEM_SP_PARITY_EN
    // Stored word has even parity, so a set XOR over all bits is a mismatch.
    assign bus.perr = r_out_valid && r_rd_ok && (^w_rd_q);
`else
    assign bus.perr = 1'b0;
`endif

endmodule
